// File: rtl/uart_rx_fifo.sv
// Circular byte FIFO between the UART receiver strobe and a valid/ready consumer.
// Write to out_valid takes one edge, with no bypass; the input side has no backpressure, so words arriving while full are dropped and flagged.
module uart_rx_fifo #(
    parameter int DATA_BITS   = 8,
    parameter int DEPTH       = 16,
    parameter int ALMOST_FULL = 12
) (
    input  logic                         clk,
    input  logic                         sresetn,
    input  logic                         in_valid,
    input  logic [DATA_BITS-1:0]         in_data,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [DATA_BITS-1:0]         out_data,
    output logic [$clog2(DEPTH+1)-1:0]   level,
    output logic                         almost_full,
    output logic                         overflow,
    input  logic                         clear_overflow
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = $clog2(DEPTH+1);

    logic [DATA_BITS-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0]     level_q, level_d;
    logic                 overflow_q, overflow_d;
    logic                 push, pop, drop;

    // A pop on the same edge frees a slot, so a full FIFO can still accept a word.
    always_comb begin
        pop  = out_valid && out_ready;
        push = in_valid && ((level_q < LVL_W'(DEPTH)) || pop);
        drop = in_valid && !push;
    end

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        level_d    = level_q;
        overflow_d = overflow_q;
        if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
        if (push && !pop)      level_d = level_q + LVL_W'(1);
        else if (pop && !push) level_d = level_q - LVL_W'(1);
        if (drop)                overflow_d = 1'b1;
        else if (clear_overflow) overflow_d = 1'b0;
    end

    always_ff @(posedge clk or negedge sresetn) begin
        if (!sresetn) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            overflow_q <= overflow_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= in_data;
    end

    always_comb begin
        out_valid   = (level_q != '0);
        out_data    = out_valid ? mem_q[rd_ptr_q] : DATA_BITS'(0);
        level       = level_q;
        almost_full = (level_q >= LVL_W'(ALMOST_FULL));
        overflow    = overflow_q;
    end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo with DEPTH=16, ALMOST_FULL=12.
module tb_uart_rx_fifo;

    logic       clk;
    logic       sresetn;
    logic       in_valid;
    logic [7:0] in_data;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_data;
    logic [4:0] level;
    logic       almost_full;
    logic       overflow;
    logic       clear_overflow;

    int n_checks = 0;
    int n_fail   = 0;

    uart_rx_fifo #(.DATA_BITS(8), .DEPTH(16), .ALMOST_FULL(12)) dut (
        .clk            (clk),
        .sresetn        (sresetn),
        .in_valid       (in_valid),
        .in_data        (in_data),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_data       (out_data),
        .level          (level),
        .almost_full    (almost_full),
        .overflow       (overflow),
        .clear_overflow (clear_overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_word(input logic [7:0] d);
        in_valid = 1'b1;
        in_data  = d;
        tick();
        in_valid = 1'b0;
        in_data  = 8'h00;
    endtask

    initial begin
        logic [7:0] q[$];
        logic [7:0] wd;
        logic [4:0] exp_lvl;
        int         pushed;
        int         cyc;
        bit         do_push, do_pop;

        sresetn = 1'b0; in_valid = 1'b0; in_data = 8'h00;
        out_ready = 1'b0; clear_overflow = 1'b0;
        #12;
        check_eq("rst_level", level, 0);
        check_eq("rst_out_valid", out_valid, 0);
        check_eq("rst_out_data", out_data, 0);
        check_eq("rst_almost_full", almost_full, 0);
        check_eq("rst_overflow", overflow, 0);
        @(posedge clk);
        #1;
        sresetn = 1'b1;
        tick();

        // three words, consumer stalled
        push_word(8'h41);
        push_word(8'h42);
        push_word(8'h43);
        check_eq("basic_level", level, 3);
        check_eq("basic_out_valid", out_valid, 1);
        check_eq("basic_head", out_data, 8'h41);
        check_eq("basic_overflow", overflow, 0);
        tick();
        check_eq("basic_head_hold", out_data, 8'h41);

        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            check_eq("drain_data", out_data, 8'h41 + i);
            check_eq("drain_level", level, 3 - i);
            tick();
        end
        out_ready = 1'b0;
        check_eq("drain_empty_valid", out_valid, 0);
        check_eq("drain_empty_data", out_data, 0);
        check_eq("drain_empty_level", level, 0);

        // fill past full
        for (int i = 0; i < 18; i++) begin
            push_word(8'(i));
            exp_lvl = (i < 16) ? 5'(i + 1) : 5'd16;
            check_eq("fill_level", level, exp_lvl);
            check_eq("fill_almost_full", almost_full, exp_lvl >= 5'd12);
            check_eq("fill_overflow", overflow, i >= 16);
        end
        clear_overflow = 1'b1;
        tick();
        clear_overflow = 1'b0;
        check_eq("clear_alone", overflow, 0);
        check_eq("clear_level", level, 16);

        // push and pop together while full
        in_valid = 1'b1; in_data = 8'hAA; out_ready = 1'b1;
        tick();
        in_valid = 1'b0; in_data = 8'h00;
        check_eq("full_pp_level", level, 16);
        check_eq("full_pp_overflow", overflow, 0);
        for (int i = 0; i < 16; i++) begin
            check_eq("full_drain_data", out_data, (i < 15) ? 8'(i + 1) : 8'hAA);
            tick();
        end
        out_ready = 1'b0;
        check_eq("full_drain_empty", out_valid, 0);

        // pointer wrap with interleaved traffic
        pushed = 0;
        cyc    = 0;
        while ((pushed < 40 || q.size() > 0) && cyc < 300) begin
            do_push = (pushed < 40) && (q.size() < 5) && (cyc % 4 != 3);
            do_pop  = (q.size() > 0) &&
                      (((q.size() > 1) && (cyc % 3 != 0)) || pushed == 40 || q.size() == 5);
            wd = 8'(8'h80 + pushed);
            if (do_pop) check_eq("wrap_data", out_data, q[0]);
            in_valid  = do_push;
            in_data   = wd;
            out_ready = do_pop;
            tick();
            if (do_pop) void'(q.pop_front());
            if (do_push) begin
                q.push_back(wd);
                pushed++;
            end
            in_valid = 1'b0; out_ready = 1'b0;
            check_eq("wrap_level", level, 5'(q.size()));
            cyc++;
        end
        if (cyc >= 300) check_eq("wrap_timeout", cyc, 0);
        check_eq("wrap_end_level", level, 0);
        check_eq("wrap_overflow", overflow, 0);

        // overflow set wins over clear
        for (int i = 0; i < 16; i++) push_word(8'(8'h10 + i));
        push_word(8'hEE);
        check_eq("ovf_set", overflow, 1);
        check_eq("ovf_level", level, 16);
        in_valid = 1'b1; in_data = 8'hEF; clear_overflow = 1'b1;
        tick();
        in_valid = 1'b0; clear_overflow = 1'b0;
        check_eq("ovf_set_wins", overflow, 1);
        clear_overflow = 1'b1;
        tick();
        clear_overflow = 1'b0;
        check_eq("ovf_cleared", overflow, 0);

        // async reset at level 7
        out_ready = 1'b1;
        repeat (9) tick();
        out_ready = 1'b0;
        check_eq("pre_rst_level", level, 7);
        check_eq("pre_rst_head", out_data, 8'h19);
        #2;
        sresetn = 1'b0;
        #1;
        check_eq("async_rst_level", level, 0);
        check_eq("async_rst_valid", out_valid, 0);
        check_eq("async_rst_data", out_data, 0);
        check_eq("async_rst_almost_full", almost_full, 0);
        tick();
        sresetn = 1'b1;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
